read_src_property_mt: RTL and testbench
=======================================

// Module: read_src_property_mt
// PURPOSE
//  Multi-outstanding successor to the single-request source-property read stage of the graph pipeline.
//  Accepts pipeline_data_t tokens and issues one property read per token to memory, tagged by buffer slot.
//  Holds up to DEPTH tokens in flight, merges the returned data and emits tokens strictly in arrival order.
//  Sits between the vertex-fetch stage (upstream) and the edge/message stages (downstream).
// PARAMETERS
//  DEPTH      4      in-flight token slots; power of two, 2..16
//  ADDR_W     32     memory address width
//  DATA_W     64     property width; must be <= 64
//  PROP_BYTES 8      byte stride per vertex property
//  BASE_ADDR  'h0    property array base address
// PORTS
//  clk              in   1        clock; all logic on the rising edge
//  reset            in   1        synchronous, active-low reset (0 = reset)
//  i_valid          in   1        upstream token valid
//  i_data           in   pipeline_data_t  upstream token; skip_read=1 means no memory access
//  p_stall_can_accept out 1       upstream ready
//  mem_req_valid    out  1        read request valid
//  mem_req_addr     out  ADDR_W   BASE_ADDR + vertex_id*PROP_BYTES, truncated to ADDR_W
//  mem_req_tag      out  TAG_W    slot index; TAG_W = $clog2(DEPTH)
//  mem_req_ready    in   1        memory accepts request
//  complete         in   1        response valid
//  mem_resp_tag     in   TAG_W    tag of response
//  src_data         in   DATA_W   response data
//  o_valid          out  1        downstream token valid
//  o_data           out  pipeline_data_t  token with src_prop = zero-extended src_data
//  n_stall_can_accept in 1        downstream ready
//  err_stray        out  1        sticky: response hit a slot not in WAIT_RESP
// BEHAVIOUR
//  - Slot states: FREE -> WAIT_ISSUE -> WAIT_RESP -> DONE -> FREE. A skip_read token goes FREE -> DONE.
//  - Pointers: tail (alloc), issue (oldest WAIT_ISSUE), head (pop); each wraps modulo DEPTH.
//    count is 0..DEPTH.
//  - Accept on i_valid && p_stall_can_accept. p_stall_can_accept = (count < DEPTH) and is independent of same-cycle pop.
//  - Issue: mem_req_valid = slot[issue] is WAIT_ISSUE. Request fires on mem_req_valid && mem_req_ready.
//    At most one request per cycle; addr/tag are stable while stalled.
//  - Response: when complete, the slot indexed by mem_resp_tag stores src_data and goes to DONE.
//    If that slot is not in WAIT_RESP, the response is dropped and err_stray is set (cleared only by reset).
//  - Output: o_valid = slot[head] is DONE. Pop on o_valid && n_stall_can_accept. o_data is held while stalled.
//  - Latency, empty buffer with ready memory:
//      accept in cycle N -> mem_req_valid in cycle N+1
//      complete in cycle M -> o_valid in cycle M+1
//      skip_read: accept in N -> o_valid in N+1
//  - Responses may return out of order; output order is always arrival order.
//  - Simultaneous events in one cycle:
//      accept and pop: count unchanged
//      accept into a slot popped the same cycle: allowed only when count < DEPTH
//      response and pop: legal on different slots
//  - Reset values: all slots FREE; pointers, count, o_valid, mem_req_valid and err_stray all 0;
//    o_data, mem_req_addr and mem_req_tag all '0.
//  - Reset mid-operation discards every token. Responses arriving after reset are stray (err_stray=1).
// CONFIGURATION
//  READ_SRC_PROP_PERF_EN defined adds three outputs, each cleared by reset and saturating at all-ones:
//    perf_req_cnt [31:0]   count of fired requests
//    perf_stall_cnt [31:0] count of cycles with i_valid && !p_stall_can_accept
//    perf_max_outst [TAG_W:0] peak number of WAIT_RESP slots
//  READ_SRC_PROP_PERF_EN undefined: these ports and their logic are absent; behaviour is otherwise identical.
// STRUCTURE
//  - types.sv package holds:
//      pipeline_data_t (vertex_id, skip_read, src_prop[63:0], payload fields)
//      slot_state_e enum {FREE, WAIT_ISSUE, WAIT_RESP, DONE}
//      PROP_ADDR_SHIFT helper
//  - Sub-module prop_slot_buffer holds:
//      slot state/data arrays
//      head/tail/issue pointers and count
//      the write port for responses
//  - The top level holds the address generation, handshakes, err_stray and the perf counters.
// TESTING
//  1. Single token, vertex_id=5, BASE_ADDR='h1000, response 'hDEAD one cycle after issue:
//     -> mem_req_addr='h1028, tag 0; o_data.src_prop='hDEAD two cycles after accept+issue.
//  2. Four tokens back-to-back, responses returned with tags 3,1,0,2 -> outputs in order 0,1,2,3 with matching data.
//  3. DEPTH=4, downstream stalled, five tokens offered:
//     -> p_stall_can_accept drops after the 4th accept; the 5th token is accepted on the first pop.
//  4. Mixed skip_read pattern 0,1,0 with the first response delayed 10 cycles:
//     -> the skip token waits; order is preserved.
//  5. Response with an unissued tag -> data dropped, err_stray=1 and held until reset.
//  6. Reset asserted with 3 slots in WAIT_RESP:
//     -> next cycle o_valid=0, count=0; late response sets err_stray.
//     With READ_SRC_PROP_PERF_EN: perf_max_outst=3 before reset, 0 after.

Source files
------------

// File: rtl/read_src_property_mt_pkg.sv
// Shared types for the multi-outstanding source-property read stage.
// The optional READ_SRC_PROP_PERF_EN build adds performance counters in the top level.
package read_src_property_mt_pkg;

  typedef struct packed {
    logic [31:0] vertex_id;
    logic        skip_read;
    logic [63:0] src_prop;
    logic [31:0] payload;
  } pipeline_data_t;

  typedef enum logic [1:0] {
    FREE       = 2'd0,
    WAIT_ISSUE = 2'd1,
    WAIT_RESP  = 2'd2,
    DONE       = 2'd3
  } slot_state_e;

  // Byte address of a vertex property; callers truncate to their address width.
  function automatic logic [63:0] prop_addr_shift(input logic [63:0] base,
                                                  input logic [31:0] vertex_id,
                                                  input logic [31:0] prop_bytes);
    return base + ({32'd0, vertex_id} * {32'd0, prop_bytes});
  endfunction

endpackage

// File: rtl/read_src_property_mt_prop_slot_buffer.sv
// In-order slot ring for read_src_property_mt: per-slot state and token storage,
// alloc/issue/pop pointers and the response write port.
module read_src_property_mt_prop_slot_buffer
  import read_src_property_mt_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TAG_W = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 acc_s,
  input  pipeline_data_t       acc_tok,
  input  logic                 fire_s,
  input  logic                 pop_s,
  input  logic                 resp_en,
  input  logic [TAG_W-1:0]     resp_tag,
  input  logic [63:0]          resp_data,
  output logic [TAG_W:0]       count,
  output logic [TAG_W-1:0]     issue_ptr,
  output logic [31:0]          issue_vid,
  output logic                 issue_wait,
  output logic                 head_done,
  output pipeline_data_t       head_tok,
  output logic                 resp_ok
`ifdef READ_SRC_PROP_PERF_EN
  , output logic [TAG_W:0]     outst_cnt
`endif
);

  slot_state_e    state_r [DEPTH];
  pipeline_data_t tok_r   [DEPTH];
  logic [TAG_W-1:0] head_r, tail_r, issue_r;
  logic [TAG_W:0]   count_r, pend_r;
  logic             issue_adv_s;

  // pend_r counts slots between issue and tail; skip tokens there are stepped over.
  assign issue_adv_s = (pend_r != '0) && (fire_s || (state_r[issue_r] != WAIT_ISSUE));
  assign resp_ok     = resp_en && (state_r[resp_tag] == WAIT_RESP);

  assign count      = count_r;
  assign issue_ptr  = issue_r;
  assign issue_vid  = tok_r[issue_r].vertex_id;
  assign issue_wait = (state_r[issue_r] == WAIT_ISSUE);
  assign head_done  = (state_r[head_r] == DONE);
  assign head_tok   = tok_r[head_r];

  // Slot lifecycle and pointer bookkeeping; all writes in one cycle target distinct slots.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        state_r[i] <= FREE;
        tok_r[i]   <= '0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      issue_r <= '0;
      count_r <= '0;
      pend_r  <= '0;
    end else begin
      if (pop_s) begin
        state_r[head_r] <= FREE;
        head_r          <= head_r + TAG_W'(1);
      end
      if (acc_s) begin
        state_r[tail_r] <= acc_tok.skip_read ? DONE : WAIT_ISSUE;
        tok_r[tail_r]   <= acc_tok;
        tail_r          <= tail_r + TAG_W'(1);
      end
      if (fire_s) begin
        state_r[issue_r] <= WAIT_RESP;
      end
      if (resp_ok) begin
        state_r[resp_tag]        <= DONE;
        tok_r[resp_tag].src_prop <= resp_data;
      end
      if (issue_adv_s) begin
        issue_r <= issue_r + TAG_W'(1);
      end
      count_r <= count_r + (TAG_W+1)'(acc_s) - (TAG_W+1)'(pop_s);
      pend_r  <= pend_r + (TAG_W+1)'(acc_s) - (TAG_W+1)'(issue_adv_s);
    end
  end

`ifdef READ_SRC_PROP_PERF_EN
  // Number of slots currently waiting on memory.
  always_comb begin
    outst_cnt = '0;
    for (int i = 0; i < DEPTH; i++) begin
      outst_cnt = outst_cnt + {{TAG_W{1'b0}}, (state_r[i] == WAIT_RESP)};
    end
  end
`endif

endmodule

// File: rtl/read_src_property_mt.sv
// Multi-outstanding source-property read stage: tagged memory reads, in-order token output.
// Define READ_SRC_PROP_PERF_EN to add perf_req_cnt, perf_stall_cnt and perf_max_outst.
module read_src_property_mt
  import read_src_property_mt_pkg::*;
#(
  parameter int                DEPTH      = 4,
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 64,
  parameter int                PROP_BYTES = 8,
  parameter logic [ADDR_W-1:0] BASE_ADDR  = '0,
  localparam int               TAG_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_valid,
  input  pipeline_data_t    i_data,
  output logic              p_stall_can_accept,
  output logic              mem_req_valid,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [TAG_W-1:0]  mem_req_tag,
  input  logic              mem_req_ready,
  input  logic              complete,
  input  logic [TAG_W-1:0]  mem_resp_tag,
  input  logic [DATA_W-1:0] src_data,
  output logic              o_valid,
  output pipeline_data_t    o_data,
  input  logic              n_stall_can_accept,
  output logic              err_stray
`ifdef READ_SRC_PROP_PERF_EN
  , output logic [31:0]      perf_req_cnt
  , output logic [31:0]      perf_stall_cnt
  , output logic [TAG_W:0]   perf_max_outst
`endif
);

  logic [TAG_W:0]   count_s;
  logic [TAG_W-1:0] issue_ptr_s;
  logic [31:0]      issue_vid_s;
  logic             issue_wait_s, head_done_s, resp_ok_s;
  pipeline_data_t   head_tok_s;
  logic             acc_s, fire_s, pop_s;
`ifdef READ_SRC_PROP_PERF_EN
  logic [TAG_W:0]   outst_cnt_s;
`endif

  // Ready depends only on occupancy so it never combinationally follows the downstream pop.
  assign p_stall_can_accept = (count_s < (TAG_W+1)'(DEPTH));
  assign acc_s              = i_valid && p_stall_can_accept;

  assign mem_req_valid = issue_wait_s;
  assign mem_req_addr  = issue_wait_s
                       ? ADDR_W'(prop_addr_shift(64'(BASE_ADDR), issue_vid_s, 32'(PROP_BYTES)))
                       : '0;
  assign mem_req_tag   = issue_wait_s ? issue_ptr_s : '0;
  assign fire_s        = mem_req_valid && mem_req_ready;

  assign o_valid = head_done_s;
  assign o_data  = head_done_s ? head_tok_s : '0;
  assign pop_s   = o_valid && n_stall_can_accept;

  read_src_property_mt_prop_slot_buffer #(
    .DEPTH (DEPTH),
    .TAG_W (TAG_W)
  ) u_slots (
    .clk        (clk),
    .reset      (reset),
    .acc_s      (acc_s),
    .acc_tok    (i_data),
    .fire_s     (fire_s),
    .pop_s      (pop_s),
    .resp_en    (complete),
    .resp_tag   (mem_resp_tag),
    .resp_data  (64'(src_data)),
    .count      (count_s),
    .issue_ptr  (issue_ptr_s),
    .issue_vid  (issue_vid_s),
    .issue_wait (issue_wait_s),
    .head_done  (head_done_s),
    .head_tok   (head_tok_s),
    .resp_ok    (resp_ok_s)
`ifdef READ_SRC_PROP_PERF_EN
    , .outst_cnt (outst_cnt_s)
`endif
  );

  // Sticky flag for responses that do not match an outstanding request.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_stray <= 1'b0;
    end else if (complete && !resp_ok_s) begin
      err_stray <= 1'b1;
    end else begin
      err_stray <= err_stray;
    end
  end

`ifdef READ_SRC_PROP_PERF_EN
  // Saturating request/stall counters and peak outstanding-read watermark.
  always_ff @(posedge clk) begin
    if (!reset) begin
      perf_req_cnt   <= '0;
      perf_stall_cnt <= '0;
      perf_max_outst <= '0;
    end else begin
      if (fire_s && (perf_req_cnt != '1)) begin
        perf_req_cnt <= perf_req_cnt + 32'd1;
      end
      if (i_valid && !p_stall_can_accept && (perf_stall_cnt != '1)) begin
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
      end
      if (outst_cnt_s > perf_max_outst) begin
        perf_max_outst <= outst_cnt_s;
      end
    end
  end
`endif

endmodule

// File: tb/tb_read_src_property_mt.sv
// Scoreboard bench for read_src_property_mt (DEPTH=4, BASE_ADDR='h1000, 32-bit response data).
// Expected tokens/requests are queued at accept time and popped by negedge monitors.
module tb_read_src_property_mt;
  import read_src_property_mt_pkg::*;

  typedef struct packed {
    logic [31:0] addr;
    logic [1:0]  tag;
  } req_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           i_valid = 1'b0;
  pipeline_data_t i_data = '0;
  logic           p_stall_can_accept;
  logic           mem_req_valid;
  logic [31:0]    mem_req_addr;
  logic [1:0]     mem_req_tag;
  logic           mem_req_ready = 1'b1;
  logic           complete = 1'b0;
  logic [1:0]     mem_resp_tag = '0;
  logic [31:0]    src_data = '0;
  logic           o_valid;
  pipeline_data_t o_data;
  logic           n_stall_can_accept = 1'b1;
  logic           err_stray;
`ifdef READ_SRC_PROP_PERF_EN
  logic [31:0]    perf_req_cnt;
  logic [31:0]    perf_stall_cnt;
  logic [2:0]     perf_max_outst;
`endif

  int             checks = 0;
  int             errors = 0;
  pipeline_data_t exp_out[$];
  req_t           exp_req[$];
  logic [31:0]    tag_data [4];
  logic [1:0]     alloc = '0;

  read_src_property_mt #(
    .DEPTH      (4),
    .ADDR_W     (32),
    .DATA_W     (32),
    .PROP_BYTES (8),
    .BASE_ADDR  (32'h1000)
  ) dut (
    .clk                (clk),
    .reset              (reset),
    .i_valid            (i_valid),
    .i_data             (i_data),
    .p_stall_can_accept (p_stall_can_accept),
    .mem_req_valid      (mem_req_valid),
    .mem_req_addr       (mem_req_addr),
    .mem_req_tag        (mem_req_tag),
    .mem_req_ready      (mem_req_ready),
    .complete           (complete),
    .mem_resp_tag       (mem_resp_tag),
    .src_data           (src_data),
    .o_valid            (o_valid),
    .o_data             (o_data),
    .n_stall_can_accept (n_stall_can_accept),
    .err_stray          (err_stray)
`ifdef READ_SRC_PROP_PERF_EN
    , .perf_req_cnt     (perf_req_cnt)
    , .perf_stall_cnt   (perf_stall_cnt)
    , .perf_max_outst   (perf_max_outst)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Output scoreboard: every downstream pop must match the oldest expected token.
  always @(negedge clk) begin
    if (reset && o_valid && n_stall_can_accept) begin
      if (exp_out.size() == 0) begin
        chk("out_unexpected", 160'(o_data), 160'd0);
      end else begin
        chk("o_data", 160'(o_data), 160'(exp_out.pop_front()));
      end
    end
  end

  // Request scoreboard: every fired request must match the oldest expected address/tag.
  always @(negedge clk) begin
    if (reset && mem_req_valid && mem_req_ready) begin
      if (exp_req.size() == 0) begin
        chk("req_unexpected", 160'(mem_req_addr), 160'd0);
      end else begin
        req_t r;
        r = exp_req.pop_front();
        chk("mem_req_addr", 160'(mem_req_addr), 160'(r.addr));
        chk("mem_req_tag", 160'(mem_req_tag), 160'(r.tag));
      end
    end
  end

  task automatic do_reset();
    reset = 1'b0;
    i_valid = 1'b0;
    complete = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    exp_out.delete();
    exp_req.delete();
    alloc = '0;
  endtask

  // Offer one token and hold it until accepted; expectations are queued on acceptance.
  task automatic send(input logic [31:0] vid, input logic skip, input logic [31:0] rdata);
    pipeline_data_t t;
    req_t r;
    logic rdy;
    int n;
    t = '0;
    t.vertex_id = vid;
    t.skip_read = skip;
    t.payload = 32'hC0DE_0000 | vid;
    i_data = t;
    i_valid = 1'b1;
    n = 0;
    rdy = 1'b0;
    while (!rdy && n < 100) begin
      @(negedge clk);
      rdy = p_stall_can_accept;
      @(posedge clk);
      #1;
      n++;
    end
    i_valid = 1'b0;
    if (!rdy) begin
      chk("accept_timeout", 160'(vid), 160'(32'hFFFF_FFFF));
    end else begin
      if (!skip) begin
        t.src_prop = {32'd0, rdata};
        tag_data[alloc] = rdata;
        r.addr = 32'h1000 + vid * 32'd8;
        r.tag = alloc;
        exp_req.push_back(r);
      end
      exp_out.push_back(t);
      alloc = alloc + 2'd1;
    end
  endtask

  task automatic respond(input logic [1:0] tag);
    complete = 1'b1;
    mem_resp_tag = tag;
    src_data = tag_data[tag];
    @(posedge clk);
    #1;
    complete = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_out.size() != 0 || exp_req.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk("drain_left", 160'(exp_out.size() + exp_req.size()), 160'd0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) tag_data[i] = 32'h0;
    do_reset();
    @(negedge clk);
    chk("rst_o_valid", 160'(o_valid), 160'd0);
    chk("rst_mem_req_valid", 160'(mem_req_valid), 160'd0);
    chk("rst_err_stray", 160'(err_stray), 160'd0);
    chk("rst_ready", 160'(p_stall_can_accept), 160'd1);
    chk("rst_addr", 160'(mem_req_addr), 160'd0);
    chk("rst_tag", 160'(mem_req_tag), 160'd0);
    chk("rst_o_data", 160'(o_data), 160'd0);
    @(posedge clk);
    #1;

    // 1: single token, vertex 5 -> 0x1028, response one cycle after issue
    send(32'd5, 1'b0, 32'hDEAD);
    @(negedge clk);
    chk("t1_req_valid", 160'(mem_req_valid), 160'd1);
    chk("t1_addr", 160'(mem_req_addr), 160'h1028);
    @(posedge clk);
    #1;
    complete = 1'b1;
    mem_resp_tag = 2'd0;
    src_data = tag_data[0];
    @(negedge clk);
    chk("t1_o_valid_early", 160'(o_valid), 160'd0);
    @(posedge clk);
    #1;
    complete = 1'b0;
    @(negedge clk);
    chk("t1_o_valid", 160'(o_valid), 160'd1);
    wait_drain();

    // 2: four tokens, responses by tag 3,1,0,2, output in arrival order
    do_reset();
    send(32'd10, 1'b0, 32'hFFFF_0001);
    send(32'd11, 1'b0, 32'hA0A0_0011);
    send(32'd12, 1'b0, 32'h0000_0012);
    send(32'd13, 1'b0, 32'h1234_5678);
    repeat (4) @(posedge clk);
    #1;
    respond(2'd3);
    respond(2'd1);
    @(negedge clk);
    chk("t2_hold_order", 160'(o_valid), 160'd0);
    @(posedge clk);
    #1;
    respond(2'd0);
    respond(2'd2);
    wait_drain();

    // 3: downstream stalled, fifth token waits for the first pop
    do_reset();
    n_stall_can_accept = 1'b0;
    send(32'd50, 1'b1, 32'd0);
    send(32'd51, 1'b1, 32'd0);
    send(32'd52, 1'b1, 32'd0);
    send(32'd53, 1'b1, 32'd0);
    @(negedge clk);
    chk("t3_full", 160'(p_stall_can_accept), 160'd0);
    @(posedge clk);
    #1;
    fork
      send(32'd54, 1'b1, 32'd0);
      begin
        repeat (3) @(posedge clk);
        #1;
        n_stall_can_accept = 1'b1;
        @(negedge clk);
        chk("t3_full_at_pop", 160'(p_stall_can_accept), 160'd0);
        @(negedge clk);
        chk("t3_ready_after_pop", 160'(p_stall_can_accept), 160'd1);
      end
    join
    wait_drain();

    // 4: skip pattern 0,1,0 with the first response delayed
    do_reset();
    send(32'd20, 1'b0, 32'h2020);
    send(32'd21, 1'b1, 32'd0);
    send(32'd22, 1'b0, 32'h2222);
    repeat (4) @(posedge clk);
    #1;
    respond(2'd2);
    repeat (10) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t4_skip_waits", 160'(o_valid), 160'd0);
    @(posedge clk);
    #1;
    respond(2'd0);
    wait_drain();

    // 5: response with unissued tag
    do_reset();
    tag_data[1] = 32'hBAD0;
    respond(2'd1);
    @(negedge clk);
    chk("t5_err_stray", 160'(err_stray), 160'd1);
    chk("t5_dropped", 160'(o_valid), 160'd0);
    repeat (5) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t5_err_sticky", 160'(err_stray), 160'd1);
    @(posedge clk);
    #1;

    // 6: reset with three reads outstanding, then a late response
    do_reset();
    send(32'd40, 1'b0, 32'h4040);
    send(32'd41, 1'b0, 32'h4141);
    send(32'd42, 1'b0, 32'h4242);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_all_issued", 160'(exp_req.size()), 160'd0);
    chk("t6_no_output", 160'(o_valid), 160'd0);
`ifdef READ_SRC_PROP_PERF_EN
    chk("t6_perf_max_pre", 160'(perf_max_outst), 160'd3);
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    exp_out.delete();
    exp_req.delete();
    alloc = '0;
    @(negedge clk);
    chk("t6_o_valid", 160'(o_valid), 160'd0);
    chk("t6_empty_ready", 160'(p_stall_can_accept), 160'd1);
    chk("t6_req_valid", 160'(mem_req_valid), 160'd0);
`ifdef READ_SRC_PROP_PERF_EN
    chk("t6_perf_max_post", 160'(perf_max_outst), 160'd0);
`endif
    @(posedge clk);
    #1;
    respond(2'd1);
    @(negedge clk);
    chk("t6_late_stray", 160'(err_stray), 160'd1);
    chk("t6_late_no_output", 160'(o_valid), 160'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
